// File: rtl/uart_rx_buf_writer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buf_writer
// Purpose  : UART receiver that packs bytes little-endian into 32-bit words
//            and writes them sequentially into a text buffer. Frames are 8N1,
//            or 8E1 when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_buf_writer #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 16,
    parameter logic [7:0]  END_CHAR     = 8'h21,
    parameter int          ADDR_W       = $clog2(DEPTH) + 2
) (
    input  logic              clk_sys_i,
    input  logic              rst_n_i,
    input  logic              uart_rx_i,
    input  logic              uart_start_i,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [31:0]       buf_data_o,
    output logic [3:0]        buf_be_o,
    output logic              rx_done_o,
    output logic              overflow_o,
    output logic              frame_err_o,
    output logic              parity_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int WC_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_half      = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [WC_W-1:0]  c_last_word = WC_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_rx_meta, r_rx_sync;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [1:0]        r_lane;
    logic [31:0]       r_word;
    logic [3:0]        r_be;
    logic [WC_W-1:0]   r_word_cnt;
    logic              r_done, r_overflow, r_frame_err;
    logic              w_shift, w_par_chk, w_byte_ok, w_frame_err, w_par_ok;
    logic              w_accept, w_is_end, w_flush;
    logic [31:0]       w_word_nxt;
    logic [3:0]        w_be_nxt;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE || w_state_nxt != r_state || r_clk_cnt == c_full)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + 1'b1;
            if (r_state != S_DATA)
                r_bit_cnt <= '0;
            else if (w_shift)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift)
                r_shift <= {r_rx_sync, r_shift[7:1]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_par_chk   = 1'b0;
        w_byte_ok   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE:   if (!r_rx_sync) w_state_nxt = S_START;
            S_START:  if (r_clk_cnt == c_half) w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA: begin
                if (r_clk_cnt == c_full) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (r_clk_cnt == c_full) begin
                    w_par_chk   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_clk_cnt == c_full) begin
                    if (r_rx_sync) begin
                        w_byte_ok   = w_par_ok;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK:  if (r_rx_sync) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (uart_start_i) w_state_nxt = S_IDLE;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, r_parity_err;

    // Even parity: the parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_chk)
                r_par_bad <= (^r_shift) ^ r_rx_sync;
            if (uart_start_i)
                r_parity_err <= 1'b0;
            else if (w_par_chk && ((^r_shift) ^ r_rx_sync))
                r_parity_err <= 1'b1;
        end
    end
    assign w_par_ok     = !r_par_bad;
    assign parity_err_o = r_parity_err;
`else
    assign w_par_ok     = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    assign w_accept   = w_byte_ok && !r_done;
    assign w_is_end   = (r_shift == END_CHAR);
    assign w_flush    = w_is_end || (r_lane == 2'd3);
    assign w_word_nxt = r_word | (32'(r_shift) << {r_lane, 3'b000});
    assign w_be_nxt   = r_be | (4'b0001 << r_lane);

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_we_o    <= 1'b0;
            buf_addr_o  <= '0;
            buf_data_o  <= '0;
            buf_be_o    <= '0;
            r_lane      <= '0;
            r_word      <= '0;
            r_be        <= '0;
            r_word_cnt  <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            buf_we_o <= 1'b0;
            if (uart_start_i) begin
                r_lane      <= '0;
                r_word      <= '0;
                r_be        <= '0;
                r_word_cnt  <= '0;
                r_done      <= 1'b0;
                r_overflow  <= 1'b0;
                r_frame_err <= 1'b0;
            end else begin
                if (w_frame_err)
                    r_frame_err <= 1'b1;
                if (w_accept) begin
                    if (w_flush) begin
                        buf_we_o   <= 1'b1;
                        buf_addr_o <= ADDR_W'({r_word_cnt, 2'b00});
                        buf_data_o <= w_word_nxt;
                        buf_be_o   <= w_be_nxt;
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_lane     <= '0;
                        r_word     <= '0;
                        r_be       <= '0;
                        if (w_is_end) begin
                            r_done <= 1'b1;
                        end else if (r_word_cnt == c_last_word) begin
                            r_done     <= 1'b1;
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_word <= w_word_nxt;
                        r_be   <= w_be_nxt;
                        r_lane <= r_lane + 1'b1;
                    end
                end
            end
        end
    end

    assign rx_done_o   = r_done;
    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buf_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_buf_writer
// Purpose  : Self-checking bench for uart_rx_buf_writer (directed scenarios
//            plus random strings against a packing reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buf_writer;

    localparam int CPB    = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 6;

    logic              clk_sys_i = 1'b0;
    logic              rst_n_i   = 1'b0;
    logic              uart_rx_i = 1'b1;
    logic              uart_start_i = 1'b0;
    logic              buf_we_o;
    logic [ADDR_W-1:0] buf_addr_o;
    logic [31:0]       buf_data_o;
    logic [3:0]        buf_be_o;
    logic              rx_done_o, overflow_o, frame_err_o, parity_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
        logic              done;
        logic              ovf;
    } wr_t;

    wr_t got_q[$];

    uart_rx_buf_writer #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .END_CHAR     (8'h21),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk_sys_i    (clk_sys_i),
        .rst_n_i      (rst_n_i),
        .uart_rx_i    (uart_rx_i),
        .uart_start_i (uart_start_i),
        .buf_we_o     (buf_we_o),
        .buf_addr_o   (buf_addr_o),
        .buf_data_o   (buf_data_o),
        .buf_be_o     (buf_be_o),
        .rx_done_o    (rx_done_o),
        .overflow_o   (overflow_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    always @(negedge clk_sys_i) begin
        if (buf_we_o)
            got_q.push_back('{addr: buf_addr_o, data: buf_data_o, be: buf_be_o,
                              done: rx_done_o, ovf: overflow_o});
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_flip);
        uart_rx_i = 1'b0;
        repeat (CPB) @(posedge clk_sys_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(posedge clk_sys_i);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx_i = (^b) ^ par_flip;
        repeat (CPB) @(posedge clk_sys_i);
`else
        if (par_flip) $display("note: parity bit not part of 8N1 frame");
`endif
        uart_rx_i = stop_v;
        repeat (CPB) @(posedge clk_sys_i);
        uart_rx_i = 1'b1;
        repeat (CPB) @(posedge clk_sys_i);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b0);
    endtask

    task automatic rearm();
        @(posedge clk_sys_i);
        uart_start_i = 1'b1;
        @(posedge clk_sys_i);
        uart_start_i = 1'b0;
        repeat (2) @(posedge clk_sys_i);
        got_q.delete();
    endtask

    task automatic test_reset();
        #1;
        total++; if (buf_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", buf_we_o); end
        total++; if (buf_addr_o !== '0) begin bad++; $display("FAIL rst_addr got=%h want=0", buf_addr_o); end
        total++; if (buf_data_o !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", buf_data_o); end
        total++; if (buf_be_o !== '0) begin bad++; $display("FAIL rst_be got=%b want=0", buf_be_o); end
        total++; if (rx_done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", rx_done_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", overflow_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b want=0", frame_err_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL rst_perr got=%b want=0", parity_err_o); end
        repeat (3) @(posedge clk_sys_i);
        @(negedge clk_sys_i);
        rst_n_i = 1'b1;
        // Armed straight out of reset: a string must land without any re-arm.
        send_str("Hi!");
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL rst_armed_writes got=%0d want=1", got_q.size()); end
        // Abort a frame mid-flight with an asynchronous reset.
        uart_rx_i = 1'b0;
        repeat (3 * CPB) @(posedge clk_sys_i);
        #3 rst_n_i = 1'b0;
        #1;
        total++; if (buf_data_o !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", buf_data_o); end
        total++; if (buf_be_o !== '0) begin bad++; $display("FAIL midrst_be got=%b want=0", buf_be_o); end
        total++; if (rx_done_o !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", rx_done_o); end
        @(negedge clk_sys_i);
        uart_rx_i = 1'b1;
        rst_n_i   = 1'b1;
        got_q.delete();
        repeat (20 * CPB) @(posedge clk_sys_i);
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL rst_idle_writes got=%0d want=0", got_q.size()); end
        total++; if (rx_done_o !== 1'b0) begin bad++; $display("FAIL rst_idle_done got=%b want=0", rx_done_o); end
    endtask

    task automatic test_short_string();
        rearm();
        send_str("Hi!");
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL short_count got=%0d want=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            total++; if (got_q[0].addr !== 6'd0) begin bad++; $display("FAIL short_addr got=%h want=0", got_q[0].addr); end
            total++; if (got_q[0].data !== 32'h00216948) begin bad++; $display("FAIL short_data got=%h want=00216948", got_q[0].data); end
            total++; if (got_q[0].be !== 4'b0111) begin bad++; $display("FAIL short_be got=%b want=0111", got_q[0].be); end
            total++; if (got_q[0].done !== 1'b1) begin bad++; $display("FAIL short_done got=%b want=1", got_q[0].done); end
        end
    endtask

    task automatic test_word_boundary();
        rearm();
        send_str("ABCDE!");
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL wb_count got=%0d want=2", got_q.size()); end
        if (got_q.size() >= 2) begin
            total++; if (got_q[0].addr !== 6'd0) begin bad++; $display("FAIL wb_addr0 got=%h want=0", got_q[0].addr); end
            total++; if (got_q[0].data !== 32'h44434241) begin bad++; $display("FAIL wb_data0 got=%h want=44434241", got_q[0].data); end
            total++; if (got_q[0].be !== 4'b1111) begin bad++; $display("FAIL wb_be0 got=%b want=1111", got_q[0].be); end
            total++; if (got_q[0].done !== 1'b0) begin bad++; $display("FAIL wb_done0 got=%b want=0", got_q[0].done); end
            total++; if (got_q[1].addr !== 6'd4) begin bad++; $display("FAIL wb_addr1 got=%h want=4", got_q[1].addr); end
            total++; if (got_q[1].data !== 32'h00002145) begin bad++; $display("FAIL wb_data1 got=%h want=00002145", got_q[1].data); end
            total++; if (got_q[1].be !== 4'b0011) begin bad++; $display("FAIL wb_be1 got=%b want=0011", got_q[1].be); end
            total++; if (got_q[1].done !== 1'b1) begin bad++; $display("FAIL wb_done1 got=%b want=1", got_q[1].done); end
        end
        total++; if (rx_done_o !== 1'b1) begin bad++; $display("FAIL wb_done_final got=%b want=1", rx_done_o); end
    endtask

    task automatic test_overflow();
        rearm();
        for (int i = 0; i < 70; i++) send_byte(8'h61, 1'b1, 1'b0);
        total++; if (got_q.size() !== DEPTH) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            total++; if (got_q[i].addr !== 6'(4 * i)) begin bad++; $display("FAIL ovf_addr[%0d] got=%h want=%h", i, got_q[i].addr, 6'(4 * i)); end
            total++; if (got_q[i].data !== 32'h61616161) begin bad++; $display("FAIL ovf_data[%0d] got=%h want=61616161", i, got_q[i].data); end
            total++; if (got_q[i].be !== 4'hF) begin bad++; $display("FAIL ovf_be[%0d] got=%b want=1111", i, got_q[i].be); end
            total++; if (got_q[i].ovf !== (i == DEPTH - 1)) begin bad++; $display("FAIL ovf_flag[%0d] got=%b want=%b", i, got_q[i].ovf, i == DEPTH - 1); end
            total++; if (got_q[i].done !== (i == DEPTH - 1)) begin bad++; $display("FAIL ovf_done[%0d] got=%b want=%b", i, got_q[i].done, i == DEPTH - 1); end
        end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_final got=%b want=1", overflow_o); end
    endtask

    task automatic test_line_errors();
        rearm();
        uart_rx_i = 1'b0;
        repeat (4) @(posedge clk_sys_i);
        uart_rx_i = 1'b1;
        repeat (4 * CPB) @(posedge clk_sys_i);
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL glitch_writes got=%0d want=0", got_q.size()); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL glitch_ferr got=%b want=0", frame_err_o); end
        send_byte(8'h58, 1'b0, 1'b0);
        total++; if (frame_err_o !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b want=1", frame_err_o); end
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL ferr_writes got=%0d want=0", got_q.size()); end
        send_str("Z!");
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL ferr_after_count got=%0d want=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            total++; if (got_q[0].addr !== 6'd0) begin bad++; $display("FAIL ferr_after_addr got=%h want=0", got_q[0].addr); end
            total++; if (got_q[0].data !== 32'h0000215A) begin bad++; $display("FAIL ferr_after_data got=%h want=0000215a", got_q[0].data); end
            total++; if (got_q[0].be !== 4'b0011) begin bad++; $display("FAIL ferr_after_be got=%b want=0011", got_q[0].be); end
        end
    endtask

    task automatic test_rearm();
        logic [7:0] b;
        rearm();
        send_byte(8'h58, 1'b0, 1'b0);
        send_str("Hi!");
        total++; if (rx_done_o !== 1'b1) begin bad++; $display("FAIL rearm_pre_done got=%b want=1", rx_done_o); end
        // 0xF0: bits 4..7 are high, so re-arming during bit 5 leaves no spurious start.
        b = 8'hF0;
        uart_rx_i = 1'b0;
        repeat (CPB) @(posedge clk_sys_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            if (i == 5) begin
                repeat (CPB / 2) @(posedge clk_sys_i);
                uart_start_i = 1'b1;
                @(posedge clk_sys_i);
                uart_start_i = 1'b0;
                repeat (CPB / 2 - 1) @(posedge clk_sys_i);
            end else begin
                repeat (CPB) @(posedge clk_sys_i);
            end
        end
        uart_rx_i = 1'b1;
        repeat (3 * CPB) @(posedge clk_sys_i);
        got_q.delete();
        total++; if (rx_done_o !== 1'b0) begin bad++; $display("FAIL rearm_done got=%b want=0", rx_done_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL rearm_ferr got=%b want=0", frame_err_o); end
        send_str("!");
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL rearm_count got=%0d want=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            total++; if (got_q[0].addr !== 6'd0) begin bad++; $display("FAIL rearm_addr got=%h want=0", got_q[0].addr); end
            total++; if (got_q[0].data !== 32'h00000021) begin bad++; $display("FAIL rearm_data got=%h want=00000021", got_q[0].data); end
            total++; if (got_q[0].be !== 4'b0001) begin bad++; $display("FAIL rearm_be got=%b want=0001", got_q[0].be); end
        end
    endtask

    task automatic test_parity();
        rearm();
`ifdef UART_RX_PARITY_EN
        send_byte(8'h51, 1'b1, 1'b1);
        total++; if (parity_err_o !== 1'b1) begin bad++; $display("FAIL par_flag got=%b want=1", parity_err_o); end
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL par_writes got=%0d want=0", got_q.size()); end
`else
        send_byte(8'h51, 1'b1, 1'b0);
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL par_tied got=%b want=0", parity_err_o); end
`endif
    endtask

    // Reference: stored = prefix up to and including the first END_CHAR, capped
    // at DEPTH*4 bytes; a word is written when full, or partial on END_CHAR.
    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] tx[$];
            logic [7:0] st[$];
            int  len, nw;
            logic term, full;
            logic [31:0] ed;
            logic [3:0]  eb;
            rearm();
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++)
                tx.push_back(($urandom_range(0, 3) == 0) ? 8'h21 : 8'($urandom_range(0, 255)));
            foreach (tx[i]) send_byte(tx[i], 1'b1, 1'b0);
            term = 1'b0;
            full = 1'b0;
            foreach (tx[i]) begin
                if (!term) begin
                    st.push_back(tx[i]);
                    if (tx[i] == 8'h21) term = 1'b1;
                    else if (st.size() == DEPTH * 4) begin term = 1'b1; full = 1'b1; end
                end
            end
            nw = (st[st.size() - 1] == 8'h21) ? (st.size() + 3) / 4 : st.size() / 4;
            total++; if (got_q.size() !== nw) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, got_q.size(), nw); end
            for (int w = 0; w < nw && w < got_q.size(); w++) begin
                ed = '0;
                eb = '0;
                for (int k = 0; k < 4; k++) begin
                    if (4 * w + k < st.size()) begin
                        ed = ed | (32'(st[4 * w + k]) << (8 * k));
                        eb = eb | (4'b0001 << k);
                    end
                end
                total++; if (got_q[w].addr !== 6'(4 * w)) begin bad++; $display("FAIL rnd%0d_addr[%0d] got=%h want=%h", it, w, got_q[w].addr, 6'(4 * w)); end
                total++; if (got_q[w].data !== ed) begin bad++; $display("FAIL rnd%0d_data[%0d] got=%h want=%h", it, w, got_q[w].data, ed); end
                total++; if (got_q[w].be !== eb) begin bad++; $display("FAIL rnd%0d_be[%0d] got=%b want=%b", it, w, got_q[w].be, eb); end
                total++; if (got_q[w].done !== (term && w == nw - 1)) begin bad++; $display("FAIL rnd%0d_done[%0d] got=%b want=%b", it, w, got_q[w].done, term && w == nw - 1); end
            end
            total++; if (rx_done_o !== term) begin bad++; $display("FAIL rnd%0d_final_done got=%b want=%b", it, rx_done_o, term); end
            total++; if (overflow_o !== full) begin bad++; $display("FAIL rnd%0d_final_ovf got=%b want=%b", it, overflow_o, full); end
        end
    endtask

    initial begin
        test_reset();
        test_short_string();
        test_word_boundary();
        test_overflow();
        test_line_errors();
        test_rearm();
        test_parity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_buf_writer.md
# uart_rx_buf_writer

Serial-to-memory UART receiver for the processor test harness. Samples an 8N1 UART line, packs received bytes little-endian into 32-bit words, and writes them sequentially into the UART text buffer at byte addresses 0, 4, 8, … up to DEPTH words. Reception terminates on the end character `'!'` (0x21) or a full buffer, then raises a sticky done flag. It fills the same buffer format that the harness's buffer scanner reads back.

## Interface

Parameters:
- CLKS_PER_BIT, 16, clk_sys_i cycles per UART bit; must be ≥ 4.
- DEPTH, 16, buffer size in 32-bit words; power of two.
- END_CHAR, 8'h21, terminating byte, which is itself stored.
- ADDR_W, $clog2(DEPTH)+2, byte-address width.

Ports (one clock `clk_sys_i`; reset `rst_n_i` is asynchronous, active-low):
- clk_sys_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- uart_rx_i  in  1  serial line, idle high, asynchronous to clk_sys_i
- uart_start_i  in  1  synchronous re-arm: clears counters and flags
- buf_we_o  out  1  one-cycle write strobe
- buf_addr_o  out  ADDR_W  byte address of the word, multiple of 4
- buf_data_o  out  32  packed word; unfilled lanes are 0
- buf_be_o  out  4  byte-lane enables; bit i covers data[8i+7:8i]
- rx_done_o  out  1  sticky: END_CHAR stored or buffer full
- overflow_o  out  1  sticky: buffer filled without END_CHAR
- frame_err_o  out  1  sticky: a byte had its stop bit sampled low
- parity_err_o  out  1  sticky parity error; constant 0 without the parity macro

## Operation

- **Input synchronizer.** uart_rx_i passes through a 2-flop synchronizer; both flops reset to 1.
- **Receive FSM** (`bit_cnt` counts bits, `clk_cnt` counts clocks within a bit):
  - IDLE → START on a synchronized low.
  - START: wait CLKS_PER_BIT/2 clocks, then resample. Low → DATA. High → IDLE with no error (glitch).
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first → STOP.
  - STOP: sample at mid-bit.
    - High → byte valid → IDLE.
    - Low → frame_err_o=1, byte dropped → BREAK.
  - BREAK: wait for a synchronized high → IDLE.
- **Packer.**
  - A valid byte goes into lane `lane_idx` (0..3) of the word register, sets that lane's be bit, and increments lane_idx.
  - A write is issued when lane 3 fills, or when the byte equals END_CHAR (partial word allowed).
  - Each write drives buf_addr_o = word_cnt×4, buf_data_o and buf_be_o; then word_cnt increments and lanes and be clear.
- **Termination.**
  - END_CHAR written: rx_done_o=1.
  - word_cnt reaches DEPTH without END_CHAR: rx_done_o=1 and overflow_o=1.
  - While rx_done_o=1, received bytes are discarded and no writes occur.
- **uart_start_i.**
  - Clears word_cnt, lane state and all sticky flags.
  - Forces the FSM to IDLE, aborting any in-flight frame; that byte is lost.
  - Takes priority over a byte completing in the same cycle.
- **Reset state.**
  - The block is armed after reset.
  - Every output is 0 during and after reset.
  - FSM is in IDLE; all counters are 0.

## Timing

- The start edge is detected 2 clocks after uart_rx_i falls (synchronizer delay).
- buf_we_o is asserted exactly 1 cycle after the stop-bit sample cycle, for 1 cycle. buf_addr_o, buf_data_o and buf_be_o are valid only while it is high; they hold their values otherwise.
- rx_done_o and overflow_o rise in the same cycle as the terminating buf_we_o.
- There is no backpressure: the buffer accepts a write every cycle. Byte spacing is ≥ 10×CLKS_PER_BIT clocks.
- A new start bit arriving immediately after a valid stop sample is accepted; IDLE is re-entered in the cycle after the stop sample.
- All address arithmetic is modulo 2^ADDR_W. word_cnt is $clog2(DEPTH)+1 bits wide so it can reach DEPTH.

## Configuration

- Macro: `UART_RX_PARITY_EN`.
- **Defined:** frame is 8E1. An even-parity bit is sampled between the data and stop bits. On mismatch, parity_err_o=1 and the byte is dropped; stop checking still applies.
- **Undefined:** frame is 8N1, and parity_err_o is tied to 0.

## Test plan

Benches run with CLKS_PER_BIT=16 and DEPTH=16; parity macro undefined unless stated.

1. **Reset.** Assert rst_n_i=0 mid-frame → all outputs 0 immediately. Release → idle, no writes.
2. **Short string.** Send "Hi!" → exactly one write: addr 0, data 32'h00216948, be 4'b0111. rx_done_o=1 in the same cycle.
3. **Word boundary.** Send "ABCDE!" → two writes:
   - addr 0, data 32'h44434241, be 4'b1111
   - addr 4, data 32'h00002145, be 4'b0011

   Then rx_done_o=1.
4. **Overflow.** Send 70 bytes of 'a' → 16 writes at addr 0..60, each data 32'h61616161, be 4'hF. overflow_o=1 and rx_done_o=1 at the 16th write; no further writes.
5. **Line errors.**
   - 4-clock low glitch → no write, no flag.
   - Byte 'X' with its stop bit low → frame_err_o=1, no write.
   - Then "Z!" → addr 0, data 32'h0000215A, be 4'b0011.
6. **Re-arm mid-frame.** Pulse uart_start_i after done and mid-byte → flags cleared, partial byte lost. Then "!" → addr 0, data 32'h00000021, be 4'b0001.
   - With `UART_RX_PARITY_EN`: a bad parity bit on 'Q' sets parity_err_o=1 and no write occurs.
